// File: rtl/ntt_addr_gen_pkg.sv
// rtl/ntt_addr_gen_pkg.sv - FSM encoding and bank-map helper shared by the NTT address generator
package ntt_addr_gen_pkg;

    // Widest transform the bank-map helper is written for
    localparam int MAX_LOGN = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } ntt_state_e;

    // Bank holding a coefficient: parity of its index (its bank address is index >> 1)
    function automatic logic bank_of(input logic [MAX_LOGN-1:0] idx);
        return ^idx;
    endfunction

endpackage

// File: rtl/ntt_addr_gen_if.sv
// rtl/ntt_addr_gen_if.sv - control, read-side and write-back signals of the NTT address generator
// Optional: NTT_AG_INTT_EN adds the inv request input
interface ntt_addr_gen_if #(
    parameter int LOGN = 10
);
    localparam int HLEN = LOGN - 1;

    logic            start;
    logic            busy;
    logic            done;
    logic            rd_en;
    logic [HLEN-1:0] raddr0;
    logic [HLEN-1:0] raddr1;
    logic            rd_swap;
    logic [LOGN-1:0] tw_addr;
    logic            wen;
    logic [HLEN-1:0] waddr0;
    logic [HLEN-1:0] waddr1;
    logic            wr_swap;
`ifdef NTT_AG_INTT_EN
    logic            inv;

    modport master (
        input  start, inv,
        output busy, done, rd_en, raddr0, raddr1, rd_swap, tw_addr,
               wen, waddr0, waddr1, wr_swap
    );

    modport slave (
        output start, inv,
        input  busy, done, rd_en, raddr0, raddr1, rd_swap, tw_addr,
               wen, waddr0, waddr1, wr_swap
    );
`else
    modport master (
        input  start,
        output busy, done, rd_en, raddr0, raddr1, rd_swap, tw_addr,
               wen, waddr0, waddr1, wr_swap
    );

    modport slave (
        output start,
        input  busy, done, rd_en, raddr0, raddr1, rd_swap, tw_addr,
               wen, waddr0, waddr1, wr_swap
    );
`endif

endinterface

// File: rtl/ntt_shift_delay.sv
// rtl/ntt_shift_delay.sv - fixed-depth register chain with synchronous clear
module ntt_shift_delay #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] chain_q [DEPTH];
    logic [WIDTH-1:0] chain_d [DEPTH];

    // Next value of every tap: input enters tap 0, each tap takes its predecessor
    always_comb begin
        chain_d[0] = din;
        for (int i = 1; i < DEPTH; i++) begin
            chain_d[i] = chain_q[i-1];
        end
    end

    // Chain registers; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                chain_q[i] <= chain_d[i];
            end
        end
    end

    assign dout = chain_q[DEPTH-1];

endmodule

// File: rtl/ntt_addr_gen.sv
// rtl/ntt_addr_gen.sv - in-place radix-2 NTT read/twiddle/write-back address sequencer
// Optional: NTT_AG_INTT_EN adds inv (sampled with start) for Gentleman-Sande order
module ntt_addr_gen #(
    parameter int LOGN   = 10,
    parameter int BF_LAT = 4
) (
    input  logic           clk,
    input  logic           rst,
    ntt_addr_gen_if.master bus
);
    import ntt_addr_gen_pkg::*;

    localparam int HLEN = LOGN - 1;
    localparam int NH   = 1 << HLEN;
    localparam int SW   = $clog2(LOGN);
    localparam int DW   = $clog2(BF_LAT + 2);
    localparam int DLY  = 1 + BF_LAT;
    localparam int WRW  = 2 * HLEN + 2;

    ntt_state_e      state_q, state_d;
    logic [SW-1:0]   stage_q, stage_d;
    logic [HLEN-1:0] k_q, k_d;
    logic [DW-1:0]   drain_q, drain_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            rd_en_q, rd_en_d;
    logic [HLEN-1:0] raddr0_q, raddr0_d;
    logic [HLEN-1:0] raddr1_q, raddr1_d;
    logic            rd_swap_q, rd_swap_d;
    logic [LOGN-1:0] tw_addr_q, tw_addr_d;
`ifdef NTT_AG_INTT_EN
    logic            inv_q, inv_d;
    logic            iss_inv;
`endif

    logic            issue;
    logic [SW-1:0]   iss_stage;
    logic [HLEN-1:0] iss_k;
    logic [SW-1:0]   iss_p;
    logic [LOGN-1:0] k_ext;
    logic [LOGN-1:0] lo_mask;
    logic [LOGN-1:0] top;
    logic [LOGN-1:0] bot;
    logic            top_bank;
    logic [WRW-1:0]  wr_bus;

    // Sequencer: chooses which butterfly (stage, k) is issued this cycle and steps the FSM
    always_comb begin
        state_d   = state_q;
        stage_d   = stage_q;
        k_d       = k_q;
        drain_d   = drain_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        issue     = 1'b0;
        iss_stage = stage_q;
        iss_k     = k_q;
`ifdef NTT_AG_INTT_EN
        inv_d     = inv_q;
        iss_inv   = inv_q;
`endif
        case (state_q)
            ST_IDLE: begin
                // The start cycle itself issues butterfly 0 so rd_en appears the next cycle
                if (bus.start) begin
                    issue     = 1'b1;
                    iss_stage = '0;
                    iss_k     = '0;
`ifdef NTT_AG_INTT_EN
                    inv_d     = bus.inv;
                    iss_inv   = bus.inv;
`endif
                    stage_d   = '0;
                    k_d       = HLEN'(1);
                    busy_d    = 1'b1;
                    state_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                issue = 1'b1;
                if (k_q == HLEN'(NH - 1)) begin
                    k_d     = '0;
                    drain_d = '0;
                    state_d = ST_DRAIN;
                end else begin
                    k_d = k_q + HLEN'(1);
                end
            end
            ST_DRAIN: begin
                // Wait until the last write-back of this stage is on the bus
                if (drain_q == DW'(BF_LAT)) begin
                    if (stage_q == SW'(LOGN - 1)) begin
                        state_d = ST_FIN;
                    end else begin
                        stage_d = stage_q + SW'(1);
                        state_d = ST_RUN;
                    end
                end else begin
                    drain_d = drain_q + DW'(1);
                end
            end
            ST_FIN: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Address math for the issued butterfly and the next values of the read-side outputs
    always_comb begin
`ifdef NTT_AG_INTT_EN
        iss_p = iss_inv ? iss_stage : (SW'(LOGN - 1) - iss_stage);
`else
        iss_p = SW'(LOGN - 1) - iss_stage;
`endif
        k_ext    = {1'b0, iss_k};
        lo_mask  = (LOGN'(1) << iss_p) - LOGN'(1);
        top      = ((k_ext & ~lo_mask) << 1) | (k_ext & lo_mask);
        bot      = top | (LOGN'(1) << iss_p);
        top_bank = bank_of(MAX_LOGN'(top));

        rd_en_d   = issue;
        raddr0_d  = '0;
        raddr1_d  = '0;
        rd_swap_d = 1'b0;
        tw_addr_d = '0;
        if (issue) begin
            raddr0_d  = top_bank ? HLEN'(bot >> 1) : HLEN'(top >> 1);
            raddr1_d  = top_bank ? HLEN'(top >> 1) : HLEN'(bot >> 1);
            rd_swap_d = top_bank;
            tw_addr_d = (LOGN'(1) << (SW'(LOGN - 1) - iss_p)) + (k_ext >> iss_p);
        end
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stage_q   <= '0;
            k_q       <= '0;
            drain_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_en_q   <= 1'b0;
            raddr0_q  <= '0;
            raddr1_q  <= '0;
            rd_swap_q <= 1'b0;
            tw_addr_q <= '0;
`ifdef NTT_AG_INTT_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            stage_q   <= stage_d;
            k_q       <= k_d;
            drain_q   <= drain_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rd_en_q   <= rd_en_d;
            raddr0_q  <= raddr0_d;
            raddr1_q  <= raddr1_d;
            rd_swap_q <= rd_swap_d;
            tw_addr_q <= tw_addr_d;
`ifdef NTT_AG_INTT_EN
            inv_q     <= inv_d;
`endif
        end
    end

    // Write-back mirrors the read side after BRAM read latency plus the butterfly pipeline
    ntt_shift_delay #(
        .WIDTH (WRW),
        .DEPTH (DLY)
    ) u_wr_delay (
        .clk  (clk),
        .rst  (rst),
        .din  ({rd_en_q, raddr0_q, raddr1_q, rd_swap_q}),
        .dout (wr_bus)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rd_en   = rd_en_q;
    assign bus.raddr0  = raddr0_q;
    assign bus.raddr1  = raddr1_q;
    assign bus.rd_swap = rd_swap_q;
    assign bus.tw_addr = tw_addr_q;
    assign {bus.wen, bus.waddr0, bus.waddr1, bus.wr_swap} = wr_bus;

endmodule
